// File: rtl/scfifo_flagged_if.sv
// rtl/scfifo_flagged_if.sv - data/handshake/status bundle for scfifo_flagged
interface scfifo_flagged_if #(
    parameter int lpm_width  = 16,
    parameter int lpm_widthu = 4
);
    logic [lpm_width-1:0] data;
    logic                 wrreq;
    logic                 rdreq;
    logic                 err_clr;
    logic [lpm_width-1:0] q;
    logic [lpm_widthu:0]  usedw;
    logic                 empty;
    logic                 full;
    logic                 almost_empty;
    logic                 almost_full;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output data, wrreq, rdreq, err_clr,
        input  q, usedw, empty, full, almost_empty, almost_full, overflow, underflow
    );

    modport slave (
        input  data, wrreq, rdreq, err_clr,
        output q, usedw, empty, full, almost_empty, almost_full, overflow, underflow
    );
endinterface

// File: rtl/scfifo_flagged.sv
// rtl/scfifo_flagged.sv - single-clock FIFO, any depth, occupancy/threshold/sticky-error flags
module scfifo_flagged #(
    parameter int    lpm_width          = 16,
    parameter int    lpm_numwords       = 16,
    parameter int    lpm_widthu         = 4,
    parameter string lpm_showahead      = "OFF",
    parameter int    almost_full_value  = 12,
    parameter int    almost_empty_value = 4
) (
    input  logic            clock,
    input  logic            sclr_n,
    scfifo_flagged_if.slave fifo
);
    localparam int UW = lpm_widthu + 1;
    localparam logic [UW-1:0]         DEPTH   = UW'(lpm_numwords);
    localparam logic [UW-1:0]         AF_TH   = UW'(almost_full_value);
    localparam logic [UW-1:0]         AE_TH   = UW'(almost_empty_value);
    localparam logic [lpm_widthu-1:0] LAST    = lpm_widthu'(lpm_numwords - 1);

    logic [lpm_width-1:0]  mem [lpm_numwords];
    logic [lpm_widthu-1:0] rdptr;
    logic [lpm_widthu-1:0] wrptr;
    logic [UW-1:0]         usedw_r;
    logic                  overflow_r;
    logic                  underflow_r;
    logic                  empty_r;
    logic                  full_r;
    logic                  rd_acc;
    logic                  wr_acc;

    // Depth need not be a power of two, so wrap is an explicit compare.
    function automatic logic [lpm_widthu-1:0] next_ptr(input logic [lpm_widthu-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty_r = (usedw_r == '0);
    assign full_r  = (usedw_r == DEPTH);
    assign rd_acc  = fifo.rdreq & ~empty_r;
    assign wr_acc  = fifo.wrreq & (~full_r | rd_acc);

    always_ff @(posedge clock) begin
        if (sclr_n && wr_acc) begin
            mem[wrptr] <= fifo.data;
        end
    end

    always_ff @(posedge clock) begin
        if (!sclr_n) begin
            rdptr       <= '0;
            wrptr       <= '0;
            usedw_r     <= '0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_acc) wrptr <= next_ptr(wrptr);
            if (rd_acc) rdptr <= next_ptr(rdptr);
            case ({wr_acc, rd_acc})
                2'b10:   usedw_r <= usedw_r + 1'b1;
                2'b01:   usedw_r <= usedw_r - 1'b1;
                default: usedw_r <= usedw_r;
            endcase
            // A new error in the same cycle as err_clr keeps the flag set.
            overflow_r  <= (overflow_r  & ~fifo.err_clr) | (fifo.wrreq & ~wr_acc);
            underflow_r <= (underflow_r & ~fifo.err_clr) | (fifo.rdreq & ~rd_acc);
        end
    end

    generate
        if (lpm_showahead == "ON") begin : g_showahead
            assign fifo.q = empty_r ? '0 : mem[rdptr];
        end else begin : g_normal
            logic [lpm_width-1:0] q_r;
            always_ff @(posedge clock) begin
                if (!sclr_n) begin
                    q_r <= '0;
                end else if (rd_acc) begin
                    q_r <= mem[rdptr];
                end
            end
            assign fifo.q = q_r;
        end
    endgenerate

    assign fifo.usedw        = usedw_r;
    assign fifo.empty        = empty_r;
    assign fifo.full         = full_r;
    assign fifo.almost_empty = (usedw_r < AE_TH);
    assign fifo.almost_full  = (usedw_r >= AF_TH);
    assign fifo.overflow     = overflow_r;
    assign fifo.underflow    = underflow_r;
endmodule

// File: tb/tb_scfifo_flagged.sv
// tb/tb_scfifo_flagged.sv - normal and show-ahead instances checked against a queue model
module tb_scfifo_flagged;
    localparam int W = 8, N = 5, WU = 3, AFV = 4, AEV = 2;

    logic         clock = 1'b0;
    logic         sclr_n;
    logic [W-1:0] data;
    logic         wrreq, rdreq, err_clr;

    always #5 clock = ~clock;

    scfifo_flagged_if #(.lpm_width(W), .lpm_widthu(WU)) bus_n ();
    scfifo_flagged_if #(.lpm_width(W), .lpm_widthu(WU)) bus_s ();

    assign bus_n.data = data;    assign bus_s.data = data;
    assign bus_n.wrreq = wrreq;  assign bus_s.wrreq = wrreq;
    assign bus_n.rdreq = rdreq;  assign bus_s.rdreq = rdreq;
    assign bus_n.err_clr = err_clr; assign bus_s.err_clr = err_clr;

    scfifo_flagged #(.lpm_width(W), .lpm_numwords(N), .lpm_widthu(WU), .lpm_showahead("OFF"),
                     .almost_full_value(AFV), .almost_empty_value(AEV))
        u_norm (.clock(clock), .sclr_n(sclr_n), .fifo(bus_n.slave));

    scfifo_flagged #(.lpm_width(W), .lpm_numwords(N), .lpm_widthu(WU), .lpm_showahead("ON"),
                     .almost_full_value(AFV), .almost_empty_value(AEV))
        u_sa (.clock(clock), .sclr_n(sclr_n), .fifo(bus_s.slave));

    logic [W-1:0] mq[$];
    logic [W-1:0] qn_m;
    logic         ovf_m, unf_m;
    int           n_checks = 0;
    int           n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic cyc(input logic w, input logic r, input logic [W-1:0] d,
                       input logic c, input logic rst);
        logic ra, wa;
        int   sz;
        wrreq = w; rdreq = r; data = d; err_clr = c; sclr_n = ~rst;
        @(posedge clock);
        if (rst) begin
            mq.delete(); qn_m = '0; ovf_m = 1'b0; unf_m = 1'b0;
        end else begin
            ra = r && (mq.size() != 0);
            wa = w && ((mq.size() != N) || ra);
            if (ra) qn_m = mq.pop_front();
            if (wa) mq.push_back(d);
            ovf_m = (ovf_m && !c) || (w && !wa);
            unf_m = (unf_m && !c) || (r && !ra);
        end
        #1;
        sz = mq.size();
        check("usedw",        bus_n.usedw,        sz);
        check("usedw_sa",     bus_s.usedw,        sz);
        check("empty",        bus_n.empty,        sz == 0);
        check("full",         bus_n.full,         sz == N);
        check("almost_empty", bus_n.almost_empty, sz < AEV);
        check("almost_full",  bus_n.almost_full,  sz >= AFV);
        check("overflow",     bus_n.overflow,     ovf_m);
        check("underflow",    bus_n.underflow,    unf_m);
        check("overflow_sa",  bus_s.overflow,     ovf_m);
        check("underflow_sa", bus_s.underflow,    unf_m);
        check("q_normal",     bus_n.q,            qn_m);
        check("q_showahead",  bus_s.q,            (sz == 0) ? '0 : mq[0]);
    endtask

    initial begin
        cyc(0, 0, 8'h00, 0, 1);
        cyc(1, 1, 8'h99, 1, 1);
        // fill with 0x11..0x15
        for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h11 + i), 0, 0);
        // overflow, clear, clear racing a new overflow
        cyc(1, 0, 8'h66, 0, 0);
        cyc(0, 0, 8'h00, 1, 0);
        cyc(1, 0, 8'h77, 1, 0);
        cyc(0, 0, 8'h00, 1, 0);
        // drain five then one underflowing read
        for (int i = 0; i < 6; i++) cyc(0, 1, 8'h00, 0, 0);
        cyc(0, 0, 8'h00, 1, 0);
        // pointer wrap with interleaved traffic
        for (int i = 0; i < 7; i++) begin
            cyc(1, 0, 8'(8'h20 + i), 0, 0);
            cyc(0, 1, 8'h00, 0, 0);
        end
        // simultaneous read/write at full, then at empty
        for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h30 + i), 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 8'(8'h40 + i), 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 8'h00, 0, 0);
        cyc(1, 1, 8'h50, 0, 0);
        // reset, show-ahead single word, reset mid-burst
        cyc(0, 0, 8'h00, 0, 1);
        cyc(1, 0, 8'hA5, 0, 0);
        cyc(1, 0, 8'hB6, 0, 0);
        cyc(1, 0, 8'hC7, 0, 0);
        cyc(1, 1, 8'hD8, 0, 1);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, 8'($urandom),
                $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 2);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
